// File: rtl/up_arb_pkg.sv
// Shared types for the uP slave-port arbiter: per-channel FSM state and an
// index-width helper for the grant pointer.
// Latency: n/a (types only). Backpressure: n/a.
package up_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Width of a grant index for n requesters (at least 1 bit).
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/up_rr_channel.sv
// One arbitrated uP channel: round-robin grant, slave handshake, timeout.
// Latency: req seen at edge E -> m_req after E; m_ack at edge F -> s_ack after F.
// Backpressure: masters hold req until their 1-cycle ack; one transaction in flight.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   s_req/s_ack       per-master request (level) and ack (pulse)
//   s_addr, s_data    flattened per-master address and write data
//   m_req/m_ack       slave handshake; m_addr slave address; m_data slave read data
//   dat               write channel: latched write data; read channel: returned read data
//   err               pulses with s_ack when the transaction ended by timeout
module up_rr_channel
  import up_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int N       = 2,
  parameter int TIMEOUT = 256,
  parameter bit IS_READ = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    s_req,
  output logic [N-1:0]    s_ack,
  input  logic [N*AW-1:0] s_addr,
  input  logic [N*DW-1:0] s_data,
  input  logic            m_ack,
  input  logic [DW-1:0]   m_data,
  output logic            m_req,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   dat,
  output logic            err
);

  localparam int GW = idx_width(N);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [GW-1:0] LAST_INIT = GW'(N - 1);

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;   // doubles as last_grant for the rotation
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            req_q, req_d;
  logic [N-1:0]    ack_q, ack_d;
  logic            err_q, err_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   dat_q, dat_d;

  logic            found;
  logic [GW-1:0]   pick;
  int              idx;

  // Search starting just after the previous grant so every requester is
  // reached within N grants.
  always_comb begin
    found = 1'b0;
    pick  = grant_q;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(grant_q) + k) % N;
      if (!found && s_req[idx]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    ack_d   = '0;
    err_d   = 1'b0;
    addr_d  = addr_q;
    dat_d   = dat_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          grant_d = pick;
          req_d   = 1'b1;
          cnt_d   = '0;
          addr_d  = s_addr[pick*AW +: AW];
          if (!IS_READ) dat_d = s_data[pick*DW +: DW];
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        // Ack is checked first so an ack coinciding with expiry completes cleanly.
        if (m_ack) begin
          state_d        = RESP;
          req_d          = 1'b0;
          ack_d[grant_q] = 1'b1;
          if (IS_READ) dat_d = m_data;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          state_d        = RESP;
          req_d          = 1'b0;
          ack_d[grant_q] = 1'b1;
          err_d          = 1'b1;
          if (IS_READ) dat_d = '0;
        end
      end
      // RESP always returns to IDLE without sampling requests, giving the
      // acked master a cycle to drop its request.
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= LAST_INIT;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      dat_q   <= dat_d;
    end
  end

  assign s_ack  = ack_q;
  assign m_req  = req_q;
  assign m_addr = addr_q;
  assign dat    = dat_q;
  assign err    = err_q;

endmodule

// File: rtl/up_gpio_arbiter.sv
// Round-robin arbiter sharing one uP slave port; read and write arbitrated independently.
// Latency: 1 cycle req->m_up_*req, 1 cycle slave ack->master ack, plus a dead cycle after each ack.
// Backpressure: requests are held until acked; a silent slave is timed out with an error.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   s_up_r*/s_up_w*                per-master read/write channels (flattened addr/data)
//   m_up_r*/m_up_w*                single slave read/write channels
//   rd_err, wr_err                 pulse with the ack of a timed-out transaction
module up_gpio_arbiter
  import up_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int BUS_WIDTH      = 4,
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_MASTERS-1:0]              s_up_rreq,
  output logic [NUM_MASTERS-1:0]              s_up_rack,
  input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0] s_up_raddr,
  output logic [BUS_WIDTH*8-1:0]              s_up_rdata,
  input  logic [NUM_MASTERS-1:0]              s_up_wreq,
  output logic [NUM_MASTERS-1:0]              s_up_wack,
  input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0] s_up_waddr,
  input  logic [NUM_MASTERS*BUS_WIDTH*8-1:0]  s_up_wdata,
  output logic                                m_up_rreq,
  input  logic                                m_up_rack,
  output logic [ADDRESS_WIDTH-1:0]            m_up_raddr,
  input  logic [BUS_WIDTH*8-1:0]              m_up_rdata,
  output logic                                m_up_wreq,
  input  logic                                m_up_wack,
  output logic [ADDRESS_WIDTH-1:0]            m_up_waddr,
  output logic [BUS_WIDTH*8-1:0]              m_up_wdata,
  output logic                                rd_err,
  output logic                                wr_err
);

  localparam int DW = BUS_WIDTH * 8;

  up_rr_channel #(
    .AW(ADDRESS_WIDTH), .DW(DW), .N(NUM_MASTERS),
    .TIMEOUT(TIMEOUT_CYCLES), .IS_READ(1'b1)
  ) u_rd (
    .clk    (clk),
    .rst    (rst),
    .s_req  (s_up_rreq),
    .s_ack  (s_up_rack),
    .s_addr (s_up_raddr),
    .s_data ('0),
    .m_ack  (m_up_rack),
    .m_data (m_up_rdata),
    .m_req  (m_up_rreq),
    .m_addr (m_up_raddr),
    .dat    (s_up_rdata),
    .err    (rd_err)
  );

  up_rr_channel #(
    .AW(ADDRESS_WIDTH), .DW(DW), .N(NUM_MASTERS),
    .TIMEOUT(TIMEOUT_CYCLES), .IS_READ(1'b0)
  ) u_wr (
    .clk    (clk),
    .rst    (rst),
    .s_req  (s_up_wreq),
    .s_ack  (s_up_wack),
    .s_addr (s_up_waddr),
    .s_data (s_up_wdata),
    .m_ack  (m_up_wack),
    .m_data ('0),
    .m_req  (m_up_wreq),
    .m_addr (m_up_waddr),
    .dat    (m_up_wdata),
    .err    (wr_err)
  );

endmodule

// File: tb/tb_up_gpio_arbiter.sv
module tb_up_gpio_arbiter;
  localparam int AW = 32;
  localparam int BW = 4;
  localparam int DW = 32;
  localparam int N  = 2;
  localparam int TO = 16;
  localparam logic [31:0] GPIO_IN = 32'hDEADBEEF;

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } cmd_t;
  typedef struct packed { logic [7:0] m; logic [31:0] data; logic err; } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    s_up_rreq, s_up_rack, s_up_wreq, s_up_wack;
  logic [N*AW-1:0] s_up_raddr, s_up_waddr;
  logic [N*DW-1:0] s_up_wdata;
  logic [DW-1:0]   s_up_rdata, m_up_rdata, m_up_wdata;
  logic            m_up_rreq, m_up_rack, m_up_wreq, m_up_wack, rd_err, wr_err;
  logic [AW-1:0]   m_up_raddr, m_up_waddr;

  always #5 clk = ~clk;

  up_gpio_arbiter #(
    .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .NUM_MASTERS(N), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .s_up_rreq(s_up_rreq), .s_up_rack(s_up_rack), .s_up_raddr(s_up_raddr), .s_up_rdata(s_up_rdata),
    .s_up_wreq(s_up_wreq), .s_up_wack(s_up_wack), .s_up_waddr(s_up_waddr), .s_up_wdata(s_up_wdata),
    .m_up_rreq(m_up_rreq), .m_up_rack(m_up_rack), .m_up_raddr(m_up_raddr), .m_up_rdata(m_up_rdata),
    .m_up_wreq(m_up_wreq), .m_up_wack(m_up_wack), .m_up_waddr(m_up_waddr), .m_up_wdata(m_up_wdata),
    .rd_err(rd_err), .wr_err(wr_err)
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  always @(posedge clk) cycle <= cycle + 1;

  cmd_t rq[N][$];
  cmd_t wq[N][$];
  exp_t rd_exp[$];
  exp_t wr_exp[$];
  cmd_t sw_exp[$];

  int   rd_mode  = 0;   // 0: normal slave, 1: never acks in BUSY, acks late
  int   rd_fixed = 0;   // nonzero forces read latency
  logic [31:0] regs[4];
  bit   overlap_seen = 0;
  int   rd_err_cnt = 0;
  int   rack_cycle = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Read masters: one process owns the whole read request vector.
  initial begin : rd_master
    int   wt[N];
    bit   busy[N];
    cmd_t c;
    s_up_rreq = '0; s_up_raddr = '0;
    for (int i = 0; i < N; i++) begin wt[i] = 0; busy[i] = 0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (busy[i]) begin
          if (s_up_rack[i] || rst) begin
            s_up_rreq[i] = 1'b0; busy[i] = 0;
          end else begin
            wt[i] = wt[i] + 1;
            if (wt[i] > 300) begin fail($sformatf("rd master %0d ack wait", i)); s_up_rreq[i] = 1'b0; busy[i] = 0; end
          end
        end else if (!rst && rq[i].size() > 0) begin
          c = rq[i].pop_front();
          s_up_raddr[i*AW +: AW] = c.addr;
          s_up_rreq[i] = 1'b1; busy[i] = 1; wt[i] = 0;
        end
      end
    end
  end

  initial begin : wr_master
    int   wt[N];
    bit   busy[N];
    cmd_t c;
    s_up_wreq = '0; s_up_waddr = '0; s_up_wdata = '0;
    for (int i = 0; i < N; i++) begin wt[i] = 0; busy[i] = 0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (busy[i]) begin
          if (s_up_wack[i] || rst) begin
            s_up_wreq[i] = 1'b0; busy[i] = 0;
          end else begin
            wt[i] = wt[i] + 1;
            if (wt[i] > 300) begin fail($sformatf("wr master %0d ack wait", i)); s_up_wreq[i] = 1'b0; busy[i] = 0; end
          end
        end else if (!rst && wq[i].size() > 0) begin
          c = wq[i].pop_front();
          s_up_waddr[i*AW +: AW] = c.addr;
          s_up_wdata[i*DW +: DW] = c.data;
          s_up_wreq[i] = 1'b1; busy[i] = 1; wt[i] = 0;
        end
      end
    end
  end

  // GPIO-like slave: addr 0 reads the input pins, other addrs read back writes.
  initial begin : rd_slave
    int k = 0;
    int lat;
    m_up_rack = 1'b0; m_up_rdata = '0;
    forever begin
      @(negedge clk);
      if (m_up_rreq) begin
        if (rd_mode == 1) begin
          for (int t = 0; t < 100 && m_up_rreq; t++) @(negedge clk);
          repeat (2) @(negedge clk);
          m_up_rdata = 32'h0BAD0BAD; m_up_rack = 1'b1;
          @(negedge clk);
          m_up_rack = 1'b0;
        end else begin
          lat = (rd_fixed != 0) ? rd_fixed : 1 + (k % 4);
          k++;
          repeat (lat - 1) @(negedge clk);
          m_up_rdata = (m_up_raddr == 0) ? GPIO_IN : regs[m_up_raddr[3:2]];
          m_up_rack = 1'b1;
          @(negedge clk);
          m_up_rack = 1'b0;
        end
      end
    end
  end

  initial begin : wr_slave
    int   k = 0;
    int   lat;
    cmd_t e;
    m_up_wack = 1'b0;
    for (int i = 0; i < 4; i++) regs[i] = '0;
    forever begin
      @(negedge clk);
      if (m_up_wreq) begin
        lat = 1 + ((k + 2) % 4);
        k++;
        repeat (lat - 1) @(negedge clk);
        if (sw_exp.size() == 0) fail("slave write unexpected");
        else begin
          e = sw_exp.pop_front();
          check("slave waddr", 64'(m_up_waddr), 64'(e.addr));
          check("slave wdata", 64'(m_up_wdata), 64'(e.data));
        end
        regs[m_up_waddr[3:2]] = m_up_wdata;
        m_up_wack = 1'b1;
        @(negedge clk);
        m_up_wack = 1'b0;
      end
    end
  end

  // Scoreboard monitor: pops an expectation whenever a master ack appears.
  initial begin : monitor
    exp_t e;
    logic [N-1:0] ev;
    forever begin
      @(negedge clk);
      if (m_up_rreq && m_up_wreq) overlap_seen = 1;
      if (rd_err) rd_err_cnt++;
      if (s_up_rack != '0) begin
        rack_cycle = cycle;
        if (rd_exp.size() == 0) fail($sformatf("rack unexpected %b", s_up_rack));
        else begin
          e = rd_exp.pop_front();
          ev = '0; ev[e.m] = 1'b1;
          check("rack master", 64'(s_up_rack), 64'(ev));
          check("rdata", 64'(s_up_rdata), 64'(e.data));
          check("rd_err", 64'(rd_err), 64'(e.err));
        end
      end else if (rd_err) fail("rd_err without rack");
      if (s_up_wack != '0) begin
        if (wr_exp.size() == 0) fail($sformatf("wack unexpected %b", s_up_wack));
        else begin
          e = wr_exp.pop_front();
          ev = '0; ev[e.m] = 1'b1;
          check("wack master", 64'(s_up_wack), 64'(ev));
          check("wr_err", 64'(wr_err), 64'(e.err));
        end
      end else if (wr_err) fail("wr_err without wack");
    end
  end

  function automatic bit pending();
    int s = rd_exp.size() + wr_exp.size() + sw_exp.size();
    for (int i = 0; i < N; i++) s += rq[i].size() + wq[i].size();
    return s != 0;
  endfunction

  task automatic wait_idle(input string name);
    int t = 0;
    while (t < 3000 && pending()) begin @(negedge clk); t++; end
    if (pending()) fail({name, " timeout"});
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_rreq(output int c);
    int t = 0;
    c = 0;
    while (t < 50 && !m_up_rreq) begin @(negedge clk); t++; end
    if (!m_up_rreq) fail("m_up_rreq never rose");
    c = cycle;
  endtask

  initial begin : main
    int c_req;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset s_up_rack",  64'(s_up_rack), 0);
    check("reset s_up_wack",  64'(s_up_wack), 0);
    check("reset m_up_rreq",  64'(m_up_rreq), 0);
    check("reset m_up_wreq",  64'(m_up_wreq), 0);
    check("reset m_up_raddr", 64'(m_up_raddr), 0);
    check("reset m_up_waddr", 64'(m_up_waddr), 0);
    check("reset m_up_wdata", 64'(m_up_wdata), 0);
    check("reset s_up_rdata", 64'(s_up_rdata), 0);
    check("reset errs",       64'({rd_err, wr_err}), 0);

    // 1: single write by M0
    wq[0].push_back('{addr: 32'h4, data: 32'h0000FFFF});
    sw_exp.push_back('{addr: 32'h4, data: 32'h0000FFFF});
    wr_exp.push_back('{m: 8'd0, data: 32'h0, err: 1'b0});
    wait_idle("t1");

    // M1 reads back the register just written
    rq[1].push_back('{addr: 32'h4, data: 32'h0});
    rd_exp.push_back('{m: 8'd1, data: 32'h0000FFFF, err: 1'b0});
    wait_idle("t1b");

    // 2: simultaneous reads; last read grant was M1 so M0 goes first
    rq[0].push_back('{addr: 32'h0, data: 32'h0});
    rq[1].push_back('{addr: 32'h0, data: 32'h0});
    rd_exp.push_back('{m: 8'd0, data: GPIO_IN, err: 1'b0});
    rd_exp.push_back('{m: 8'd1, data: GPIO_IN, err: 1'b0});
    wait_idle("t2");
    check("rdata held", 64'(s_up_rdata), 64'(GPIO_IN));

    // 3: 100 contended writes; last write grant was M0 so M1 leads
    for (int k = 0; k < 50; k++) begin
      wq[0].push_back('{addr: 32'h4, data: 32'h10000000 + k});
      wq[1].push_back('{addr: 32'h8, data: 32'h20000000 + k});
      wr_exp.push_back('{m: 8'd1, data: 32'h0, err: 1'b0});
      sw_exp.push_back('{addr: 32'h8, data: 32'h20000000 + k});
      wr_exp.push_back('{m: 8'd0, data: 32'h0, err: 1'b0});
      sw_exp.push_back('{addr: 32'h4, data: 32'h10000000 + k});
    end
    wait_idle("t3");

    // 4: concurrent read and write
    overlap_seen = 0;
    rq[0].push_back('{addr: 32'h0, data: 32'h0});
    wq[1].push_back('{addr: 32'h0, data: 32'hBABEDEAD});
    rd_exp.push_back('{m: 8'd0, data: GPIO_IN, err: 1'b0});
    wr_exp.push_back('{m: 8'd1, data: 32'h0, err: 1'b0});
    sw_exp.push_back('{addr: 32'h0, data: 32'hBABEDEAD});
    wait_idle("t4");
    check("rd/wr overlap", 64'(overlap_seen), 1);

    // 5: silent slave, timeout after 16 BUSY cycles, then a late stray ack
    rd_mode = 1;
    rd_err_cnt = 0;
    rq[0].push_back('{addr: 32'h0, data: 32'h0});
    rd_exp.push_back('{m: 8'd0, data: 32'h0, err: 1'b1});
    wait_rreq(c_req);
    wait_idle("t5");
    check("timeout busy cycles", 64'(rack_cycle - c_req), 16);
    repeat (10) @(negedge clk);
    check("rd_err pulses", 64'(rd_err_cnt), 1);
    rd_mode = 0;

    // 6: reset while BUSY abandons the read; rotation restarts at M0
    rd_fixed = 4;
    rq[0].push_back('{addr: 32'h0, data: 32'h0});
    wait_rreq(c_req);
    @(negedge clk);
    check("rreq before reset", 64'(m_up_rreq), 1);
    rst = 1'b1;
    @(negedge clk);
    check("rreq after reset", 64'(m_up_rreq), 0);
    check("rack in reset", 64'(s_up_rack), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    rd_fixed = 0;
    rq[0].push_back('{addr: 32'h0, data: 32'h0});
    rq[1].push_back('{addr: 32'h0, data: 32'h0});
    rd_exp.push_back('{m: 8'd0, data: GPIO_IN, err: 1'b0});
    rd_exp.push_back('{m: 8'd1, data: GPIO_IN, err: 1'b0});
    wait_idle("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
